// File: rtl/keypad_matrix_scanner_if.sv
// Keypad matrix scanner interface: row drive, column sense and decoded key outputs.
interface keypad_matrix_scanner_if;
    logic [3:0] row;
    logic [3:0] col;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_down;

    // Scanner side drives the rows and key outputs; keypad side drives the columns.
    modport master (
        output row,
        output key_valid,
        output key_code,
        output key_down,
        input  col
    );

    modport slave (
        input  row,
        input  key_valid,
        input  key_code,
        input  key_down,
        output col
    );
endinterface

// File: rtl/keypad_matrix_scanner.sv
// 4x4 active-low matrix keypad scanner with tick-paced scanning and press/release debounce.
module keypad_matrix_scanner #(
    parameter int unsigned TICK_DIV   = 1000000,
    parameter int unsigned DEBOUNCE_N = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    keypad_matrix_scanner_if.master        kp_io
);
    localparam int unsigned     CntW     = $clog2(TICK_DIV);
    localparam logic [CntW-1:0] TickLast = CntW'(TICK_DIV - 1);
    localparam logic [3:0]      DebLast  = 4'(DEBOUNCE_N);

    typedef enum logic [1:0] {StScan, StDebounce, StPressed, StRelease} state_e;

    logic [CntW-1:0] tick_cnt_q;
    logic            tick;
    logic [3:0]      col_meta_q;
    logic [3:0]      col_s_q;
    state_e          state_q;
    logic [1:0]      row_idx_q;
    logic [1:0]      col_idx_q;
    logic [3:0]      row_q;
    logic [3:0]      deb_cnt_q;
    logic [3:0]      deb_cnt_inc;
    logic            key_valid_q;
    logic [3:0]      key_code_q;
    logic            key_down_q;
    logic [1:0]      col_sel;
    logic            col_low;

    // Free-running scan step divider; tick marks the last cycle of each step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt_q <= '0;
        end else if (tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + CntW'(1);
        end
    end

    assign tick = (tick_cnt_q == TickLast);

    // Two-flop synchronizer for the asynchronous column inputs; idle level is all high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_meta_q <= 4'hF;
            col_s_q    <= 4'hF;
        end else begin
            col_meta_q <= kp_io.col;
            col_s_q    <= col_meta_q;
        end
    end

    // Priority encoder: lowest-index low column wins.
    always_comb begin
        col_sel = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!col_s_q[i]) begin
                col_sel = 2'(i);
            end
        end
    end

    assign col_low     = ~col_s_q[col_idx_q];
    assign deb_cnt_inc = deb_cnt_q + 4'd1;

    // Scan/debounce FSM with registered row drive and key outputs; only moves on ticks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StScan;
            row_idx_q   <= 2'd0;
            row_q       <= 4'b1110;
            col_idx_q   <= 2'd0;
            deb_cnt_q   <= 4'd0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'd0;
            key_down_q  <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            if (tick) begin
                unique case (state_q)
                    StScan: begin
                        if (col_s_q == 4'hF) begin
                            row_idx_q <= row_idx_q + 2'd1;
                            row_q     <= {row_q[2:0], row_q[3]};
                        end else begin
                            col_idx_q <= col_sel;
                            deb_cnt_q <= 4'd1;
                            state_q   <= StDebounce;
                        end
                    end
                    StDebounce: begin
                        if (col_low) begin
                            deb_cnt_q <= deb_cnt_inc;
                            if (deb_cnt_inc == DebLast) begin
                                state_q     <= StPressed;
                                key_code_q  <= {row_idx_q, col_idx_q};
                                key_valid_q <= 1'b1;
                                key_down_q  <= 1'b1;
                            end
                        end else begin
                            // Bounce: drop the candidate silently and keep scanning.
                            state_q   <= StScan;
                            row_idx_q <= row_idx_q + 2'd1;
                            row_q     <= {row_q[2:0], row_q[3]};
                        end
                    end
                    StPressed: begin
                        if (!col_low) begin
                            deb_cnt_q <= 4'd1;
                            state_q   <= StRelease;
                        end
                    end
                    StRelease: begin
                        if (!col_low) begin
                            deb_cnt_q <= deb_cnt_inc;
                            if (deb_cnt_inc == DebLast) begin
                                key_down_q <= 1'b0;
                                state_q    <= StScan;
                                row_idx_q  <= row_idx_q + 2'd1;
                                row_q      <= {row_q[2:0], row_q[3]};
                            end
                        end else begin
                            // Release glitch: key is still held, no new event.
                            state_q <= StPressed;
                        end
                    end
                    default: state_q <= StScan;
                endcase
            end
        end
    end

    assign kp_io.row       = row_q;
    assign kp_io.key_valid = key_valid_q;
    assign kp_io.key_code  = key_code_q;
    assign kp_io.key_down  = key_down_q;
endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Directed bench for keypad_matrix_scanner (TICK_DIV=4; DEBOUNCE_N=2 and a second DUT at 3).
module tb_keypad_matrix_scanner;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   pulses;
    int   pulses3;
    int   base;

    keypad_matrix_scanner_if kif();
    keypad_matrix_scanner_if kif3();

    keypad_matrix_scanner #(.TICK_DIV(4), .DEBOUNCE_N(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .kp_io (kif)
    );

    keypad_matrix_scanner #(.TICK_DIV(4), .DEBOUNCE_N(3)) dut3 (
        .clk   (clk),
        .rst   (rst),
        .kp_io (kif3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // key_valid cycle counters (one count per high cycle)
    initial begin
        pulses  = 0;
        pulses3 = 0;
    end
    always @(negedge clk) begin
        if (kif.key_valid === 1'b1) pulses <= pulses + 1;
        if (kif3.key_valid === 1'b1) pulses3 <= pulses3 + 1;
    end

    // Reset both DUTs; returns at the release negedge (tick counter at 0).
    task automatic apply_reset();
        kif.col  = 4'hF;
        kif3.col = 4'hF;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // One scan step: drive col right after a tick edge, return after the next tick edge.
    task automatic step(input logic [3:0] c);
        kif.col = c;
        repeat (4) @(negedge clk);
    endtask

    task automatic step3(input logic [3:0] c);
        kif3.col = c;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [3:0] exp_row;
        kif.col  = 4'hF;
        kif3.col = 4'hF;
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (kif.row !== 4'b1110) begin
            n_fail++; $display("FAIL reset_row: got %b want 1110", kif.row);
        end
        n_checks++;
        if (kif.key_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_key_valid: got %b want 0", kif.key_valid);
        end
        n_checks++;
        if (kif.key_code !== 4'd0) begin
            n_fail++; $display("FAIL reset_key_code: got %0d want 0", kif.key_code);
        end
        n_checks++;
        if (kif.key_down !== 1'b0) begin
            n_fail++; $display("FAIL reset_key_down: got %b want 0", kif.key_down);
        end
        rst = 1'b1;
        for (int j = 0; j <= 16; j++) begin
            exp_row = ~(4'b0001 << ((j / 4) % 4));
            n_checks++;
            if (kif.row !== exp_row) begin
                n_fail++;
                $display("FAIL scan_row[%0d]: got %b want %b", j, kif.row, exp_row);
            end
            if (j < 16) @(negedge clk);
        end
    endtask

    task automatic test_clean_press();
        apply_reset();
        base = pulses;
        step(4'hF);
        step(4'hF);
        n_checks++;
        if (kif.row !== 4'b1011) begin
            n_fail++; $display("FAIL press_row2: got %b want 1011", kif.row);
        end
        step(4'b1101);
        n_checks++;
        if (kif.key_down !== 1'b0) begin
            n_fail++; $display("FAIL press_early_down: got %b want 0", kif.key_down);
        end
        step(4'b1101);
        n_checks++;
        if (kif.key_valid !== 1'b1) begin
            n_fail++; $display("FAIL press_valid: got %b want 1", kif.key_valid);
        end
        n_checks++;
        if (kif.key_code !== 4'd9) begin
            n_fail++; $display("FAIL press_code: got %0d want 9", kif.key_code);
        end
        n_checks++;
        if (kif.key_down !== 1'b1) begin
            n_fail++; $display("FAIL press_down: got %b want 1", kif.key_down);
        end
        step(4'b1101);
        step(4'hF);
        n_checks++;
        if (kif.key_down !== 1'b1) begin
            n_fail++; $display("FAIL press_down_rel1: got %b want 1", kif.key_down);
        end
        n_checks++;
        if (kif.row !== 4'b1011) begin
            n_fail++; $display("FAIL press_row_held: got %b want 1011", kif.row);
        end
        step(4'hF);
        n_checks++;
        if (kif.key_down !== 1'b0) begin
            n_fail++; $display("FAIL press_released: got %b want 0", kif.key_down);
        end
        n_checks++;
        if (kif.row !== 4'b0111) begin
            n_fail++; $display("FAIL press_resume_row3: got %b want 0111", kif.row);
        end
        n_checks++;
        if (kif.key_code !== 4'd9) begin
            n_fail++; $display("FAIL press_code_hold: got %0d want 9", kif.key_code);
        end
        n_checks++;
        if (pulses - base !== 1) begin
            n_fail++; $display("FAIL press_pulses: got %0d want 1", pulses - base);
        end
    endtask

    task automatic test_bounce();
        apply_reset();
        base = pulses;
        step(4'b1011);
        step(4'hF);
        n_checks++;
        if (kif.row !== 4'b1101) begin
            n_fail++; $display("FAIL bounce_row: got %b want 1101", kif.row);
        end
        n_checks++;
        if (kif.key_down !== 1'b0) begin
            n_fail++; $display("FAIL bounce_down: got %b want 0", kif.key_down);
        end
        n_checks++;
        if (kif.key_code !== 4'd0) begin
            n_fail++; $display("FAIL bounce_code: got %0d want 0", kif.key_code);
        end
        n_checks++;
        if (pulses - base !== 0) begin
            n_fail++; $display("FAIL bounce_pulses: got %0d want 0", pulses - base);
        end
    endtask

    task automatic test_multi_column();
        apply_reset();
        base = pulses;
        step(4'hF);
        step(4'b0110);
        step(4'b0110);
        n_checks++;
        if (kif.key_code !== 4'd4) begin
            n_fail++; $display("FAIL multi_code: got %0d want 4", kif.key_code);
        end
        step(4'hF);
        step(4'hF);
        n_checks++;
        if (pulses - base !== 1) begin
            n_fail++; $display("FAIL multi_pulses: got %0d want 1", pulses - base);
        end
        n_checks++;
        if (kif.row !== 4'b1011) begin
            n_fail++; $display("FAIL multi_resume_row: got %b want 1011", kif.row);
        end
    endtask

    task automatic test_release_bounce();
        apply_reset();
        base = pulses;
        step(4'b0111);
        step(4'b0111);
        n_checks++;
        if (kif.key_code !== 4'd3) begin
            n_fail++; $display("FAIL relb_code: got %0d want 3", kif.key_code);
        end
        step(4'hF);
        n_checks++;
        if (kif.key_down !== 1'b1) begin
            n_fail++; $display("FAIL relb_glitch_down: got %b want 1", kif.key_down);
        end
        for (int k = 0; k < 3; k++) begin
            step(4'b0111);
            n_checks++;
            if (kif.key_down !== 1'b1) begin
                n_fail++; $display("FAIL relb_held_down[%0d]: got %b want 1", k, kif.key_down);
            end
        end
        step(4'hF);
        n_checks++;
        if (kif.key_down !== 1'b1) begin
            n_fail++; $display("FAIL relb_rel1_down: got %b want 1", kif.key_down);
        end
        step(4'hF);
        n_checks++;
        if (kif.key_down !== 1'b0) begin
            n_fail++; $display("FAIL relb_rel2_down: got %b want 0", kif.key_down);
        end
        n_checks++;
        if (kif.row !== 4'b1101) begin
            n_fail++; $display("FAIL relb_resume_row: got %b want 1101", kif.row);
        end
        n_checks++;
        if (pulses - base !== 1) begin
            n_fail++; $display("FAIL relb_pulses: got %0d want 1", pulses - base);
        end
    endtask

    task automatic test_reset_midop();
        apply_reset();
        base = pulses3;
        // Abort in DEBOUNCE on key 15
        step3(4'hF);
        step3(4'hF);
        step3(4'hF);
        step3(4'b0111);
        step3(4'b0111);
        kif3.col = 4'b0111;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (kif3.row !== 4'b1110) begin
            n_fail++; $display("FAIL abort_deb_row: got %b want 1110", kif3.row);
        end
        n_checks++;
        if (kif3.key_down !== 1'b0 || kif3.key_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_deb_outs: got down=%b valid=%b want 0 0",
                     kif3.key_down, kif3.key_valid);
        end
        @(negedge clk);
        kif3.col = 4'hF;
        @(negedge clk);
        rst = 1'b1;
        step3(4'hF);
        n_checks++;
        if (kif3.row !== 4'b1101) begin
            n_fail++; $display("FAIL abort_deb_restart: got %b want 1101", kif3.row);
        end
        n_checks++;
        if (pulses3 - base !== 0) begin
            n_fail++; $display("FAIL abort_deb_pulses: got %0d want 0", pulses3 - base);
        end
        // Reach PRESSED on key 15, then abort
        step3(4'hF);
        step3(4'hF);
        step3(4'b0111);
        step3(4'b0111);
        step3(4'b0111);
        n_checks++;
        if (kif3.key_valid !== 1'b1 || kif3.key_code !== 4'd15 || kif3.key_down !== 1'b1) begin
            n_fail++;
            $display("FAIL n3_press: got valid=%b code=%0d down=%b want 1 15 1",
                     kif3.key_valid, kif3.key_code, kif3.key_down);
        end
        step3(4'b0111);
        kif3.col = 4'b0111;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (kif3.key_code !== 4'd0 || kif3.key_down !== 1'b0 || kif3.key_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_pr_outs: got code=%0d down=%b valid=%b want 0 0 0",
                     kif3.key_code, kif3.key_down, kif3.key_valid);
        end
        n_checks++;
        if (kif3.row !== 4'b1110) begin
            n_fail++; $display("FAIL abort_pr_row: got %b want 1110", kif3.row);
        end
        @(negedge clk);
        kif3.col = 4'hF;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (kif3.row !== 4'b1110) begin
            n_fail++; $display("FAIL abort_pr_row0_hold: got %b want 1110", kif3.row);
        end
        @(negedge clk);
        n_checks++;
        if (kif3.row !== 4'b1101) begin
            n_fail++; $display("FAIL abort_pr_row1: got %b want 1101", kif3.row);
        end
        step3(4'hF);
        n_checks++;
        if (pulses3 - base !== 1) begin
            n_fail++; $display("FAIL n3_pulses: got %0d want 1", pulses3 - base);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        kif.col  = 4'hF;
        kif3.col = 4'hF;
        test_reset();
        test_clean_press();
        test_bounce();
        test_multi_column();
        test_release_bounce();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
